// File: rtl/module_teclado.sv
// module_teclado: 4x4 matrix-keypad scanner with single-key debounce.
// Drives one-hot column strobes and synchronizes the row inputs.
// Registers the row vector B of one accepted key at a time.
// B returns to zero between keys, so a downstream 0 -> nonzero edge marks a fresh press.
module module_teclado #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] B,
    output logic [3:0] codigo,
    output logic       tecla_valida
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [3:0]         filas_s1_q;
    logic [3:0]         filas_s2_q;
    logic [3:0]         columnas_q;
    logic [3:0]         ref_q;
    logic [3:0]         b_q;
    logic [3:0]         codigo_q;
    logic               valida_q;
    logic [DIV_W-1:0]   div_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         blank_q;

    logic [3:0]         fs;
    logic               blank_d;
    logic [3:0]         col_rot_d;
    logic               div_tc_d;
    logic               cnt_done_d;

    // Index of the lowest set bit; picks the row for multi-row presses and
    // encodes the one-hot column.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign fs         = filas_s2_q;
    assign blank_d    = (blank_q != 2'd0);
    assign col_rot_d  = {columnas_q[2:0], columnas_q[3]};
    assign div_tc_d   = (div_q == DIV_W'(SCAN_DIV - 1));
    assign cnt_done_d = (cnt_q == CNT_W'(DEBOUNCE_CYCLES));

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            filas_s1_q <= 4'b0000;
            filas_s2_q <= 4'b0000;
        end else begin
            filas_s1_q <= filas;
            filas_s2_q <= filas_s1_q;
        end
    end

    // Scan / debounce / hold / release FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            columnas_q <= 4'b0001;
            ref_q      <= 4'b0000;
            b_q        <= 4'b0000;
            codigo_q   <= 4'b0000;
            valida_q   <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            blank_q    <= 2'd0;
        end else begin
            // Rows still settling from the previous column are ignored for
            // two cycles after every column change.
            if (blank_d) blank_q <= blank_q - 2'd1;

            case (state_q)
                SCAN: begin
                    if (fs != 4'b0000 && !blank_d) begin
                        // A candidate key: freeze the column on it.
                        state_q <= DEBOUNCE;
                        ref_q   <= fs;
                        cnt_q   <= CNT_W'(1);
                        div_q   <= '0;
                    end else if (div_tc_d) begin
                        columnas_q <= col_rot_d;
                        div_q      <= '0;
                        blank_q    <= 2'd2;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (fs != ref_q) begin
                        // Bounce or pattern change: resume scanning here.
                        state_q <= SCAN;
                    end else if (cnt_done_d) begin
                        state_q  <= PRESSED;
                        b_q      <= ref_q;
                        codigo_q <= {lowest_idx(ref_q), lowest_idx(columnas_q)};
                        valida_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    // Outputs and column are held; only a full release matters.
                    if (fs == 4'b0000) begin
                        state_q <= RELEASE;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (fs != 4'b0000) begin
                        cnt_q <= '0;
                    end else if (cnt_done_d) begin
                        state_q    <= SCAN;
                        b_q        <= 4'b0000;
                        valida_q   <= 1'b0;
                        columnas_q <= col_rot_d;
                        div_q      <= '0;
                        blank_q    <= 2'd2;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign columnas     = columnas_q;
    assign B            = b_q;
    assign codigo       = codigo_q;
    assign tecla_valida = valida_q;

endmodule

// File: tb/tb_module_teclado.sv
// Testbench for module_teclado (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// A keypad model closes one key (row pattern on one column).
// Each expected output event is queued by the stimulus.
// A monitor pops it when B/codigo/tecla_valida change.
module tb_module_teclado;

    logic       clk;
    logic       rst;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] B;
    logic [3:0] codigo;
    logic       tecla_valida;

    logic [3:0] key_row = 4'b0000;
    logic [3:0] key_col = 4'b0000;
    int         cyc     = 0;
    int         checks  = 0;
    int         errors  = 0;
    int         starts  = 0;

    typedef struct {
        logic [8:0] val;   // {B, codigo, tecla_valida}
        int         cyc;   // expected cycle, or -1 when not pinned
    } exp_t;
    exp_t exp_q[$];

    module_teclado #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .filas        (filas),
        .columnas     (columnas),
        .B            (B),
        .codigo       (codigo),
        .tecla_valida (tecla_valida)
    );

    // Keypad: the closed key connects its column strobe to its rows.
    assign filas = (columnas == key_col) ? key_row : 4'b0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic [3:0] b, input logic [3:0] c, input logic v, input int at);
        exp_t e;
        e.val = {b, c, v};
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Wait until the column strobe switches onto col.
    task automatic wait_col(input logic [3:0] col);
        logic [3:0] last;
        bit ok;
        last = columnas;
        ok   = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (columnas == col && last != col) begin
                ok = 1;
                break;
            end
            last = columnas;
        end
        chk("wait_col", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_tv(input logic v);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tecla_valida === v) begin
                ok = 1;
                break;
            end
        end
        chk("wait_tv", {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_col"}, {28'd0, columnas}, 32'h1);
        chk({name, "_B"}, {28'd0, B}, 32'h0);
        chk({name, "_cod"}, {28'd0, codigo}, 32'h0);
        chk({name, "_tv"}, {31'd0, tecla_valida}, 32'h0);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("reset");

        // Idle scan: column rotates every 4 cycles, B/tecla_valida stay 0.
        for (int n = 0; n < 20; n++) begin
            logic [3:0] one;
            @(negedge clk);
            one = 4'b0001;
            chk("scan_col", {28'd0, columnas}, {28'd0, one << ((n / 4) % 4)});
            chk("scan_idle", {27'd0, B, tecla_valida}, 32'd0);
        end

        fork
            // Monitor: every output change must match the head of the queue.
            begin : monitor
                logic [8:0] prev;
                logic [8:0] cur;
                exp_t e;
                prev = {B, codigo, tecla_valida};
                forever begin
                    @(negedge clk);
                    cur = {B, codigo, tecla_valida};
                    if (cur !== prev) begin
                        if (cur[8:5] != 4'b0000 && prev[8:5] == 4'b0000) starts++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_event: got %0h expected no change (cycle %0d)", cur, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("event_val", {23'd0, cur}, {23'd0, e.val});
                            if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
                        end
                    end
                    prev = cur;
                end
            end
            begin : stimulus
                // Clean press on column 0010, row 2, held 40 cycles.
                wait_col(4'b0010);
                key_col = 4'b0010;
                key_row = 4'b0100;
                expect_ev(4'b0100, 4'b1001, 1'b1, cyc + 11);
                repeat (5) @(negedge clk);
                chk("frozen_col", {28'd0, columnas}, 32'h2);
                repeat (35) @(negedge clk);
                key_row = 4'b0000;
                expect_ev(4'b0000, 4'b1001, 1'b0, cyc + 11);
                wait_tv(1'b0);
                chk("start_once", starts, 1);

                // Bouncing contact: 3-cycle toggles never qualify.
                for (int i = 0; i < 10; i++) begin
                    key_row = (i % 2 == 0) ? 4'b0100 : 4'b0000;
                    repeat (3) @(negedge clk);
                end
                key_row = 4'b0100;
                expect_ev(4'b0100, 4'b1001, 1'b1, -1);
                wait_tv(1'b1);
                chk("bounce_start", starts, 2);

                // Release with a one-cycle glitch after 5 zero cycles.
                repeat (2) @(negedge clk);
                t = cyc;
                key_row = 4'b0000;
                expect_ev(4'b0000, 4'b1001, 1'b0, t + 17);
                repeat (5) @(negedge clk);
                key_row = 4'b0100;
                @(negedge clk);
                key_row = 4'b0000;
                wait_tv(1'b0);
                chk("resume_col", {28'd0, columnas}, 32'h4);

                // Two rows on column 1000.
                key_col = 4'b1000;
                key_row = 4'b1010;
                expect_ev(4'b1010, 4'b0111, 1'b1, -1);
                wait_tv(1'b1);
                repeat (3) @(negedge clk);
                key_row = 4'b0000;
                expect_ev(4'b0000, 4'b0111, 1'b0, -1);
                wait_tv(1'b0);

                // Reset in the middle of a debounce.
                wait_col(4'b0100);
                key_col = 4'b0100;
                key_row = 4'b0001;
                repeat (5) @(negedge clk);
                chk("deb_frozen", {28'd0, columnas}, 32'h4);
                expect_ev(4'b0000, 4'b0000, 1'b0, -1);
                rst = 1'b1;
                key_row = 4'b0000;
                @(negedge clk);
                chk_reset_state("rst_deb");
                rst = 1'b0;

                // Reset while a key is held.
                wait_col(4'b0010);
                key_col = 4'b0010;
                key_row = 4'b1000;
                expect_ev(4'b1000, 4'b1101, 1'b1, -1);
                wait_tv(1'b1);
                repeat (3) @(negedge clk);
                expect_ev(4'b0000, 4'b0000, 1'b0, -1);
                rst = 1'b1;
                key_row = 4'b0000;
                @(negedge clk);
                chk_reset_state("rst_prs");
                rst = 1'b0;

                repeat (10) @(negedge clk);
                chk("queue_empty", exp_q.size(), 0);
                chk("start_total", starts, 4);
            end
            begin : watchdog
                repeat (20000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL timeout: got cycle %0d expected completion", cyc);
            end
        join_any
        disable fork;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_teclado.md
Name: module_teclado

Overview:
- Matrix-keypad scanner and debouncer that produces the 4-bit key vector B consumed by module_evaluar.
- module_evaluar pulses start on B's 0-to-nonzero transition, so this block guarantees:
  - B changes only on debounced press/release events.
  - B stays 0 between keys.
- It drives one-hot column strobes, synchronizes the row inputs, debounces one key at a time and latches a key code.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays active while scanning. Minimum 4.
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a press or a release. Minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- filas  input  4  keypad rows, active-high (external pull-downs), asynchronous to clk.
- columnas  output  4  one-hot active-high column drive.
- B  output  4  debounced row vector of the accepted key; 0 when no key is held.
- codigo  output  4  key code {row_idx[1:0], col_idx[1:0]}.
- tecla_valida  output  1  high while an accepted key is held.

Behaviour:
- Reset values: columnas=4'b0001, B=0, codigo=0, tecla_valida=0, FSM=SCAN, all counters 0.
- Reset has priority over every other event, including reset asserted mid-debounce or while PRESSED.
- filas pass through a 2-flop synchronizer; fs denotes the synchronized vector.
- Column blanking: for the first 2 cycles after any column change, fs is ignored.
- FSM states:
  - SCAN:
    - A divider counts 0..SCAN_DIV-1.
    - At terminal count, columnas rotates left (0001->0010->0100->1000->0001, wrap-around) and the divider clears.
    - If fs!=0 outside blanking, go to DEBOUNCE. Capture ref=fs, set cnt=1, freeze the column and clear the divider.
  - DEBOUNCE:
    - If fs==ref, cnt increments.
    - If fs!=ref (including fs==0 or a different nonzero pattern), return to SCAN, resuming rotation from the frozen column.
    - When cnt==DEBOUNCE_CYCLES, go to PRESSED and register: B=ref, codigo={index of lowest set bit of ref, index of active column}, tecla_valida=1.
  - PRESSED:
    - B, codigo and the column are held constant even if fs changes among nonzero values.
    - If fs==0, go to RELEASE with cnt=1.
  - RELEASE:
    - If fs==0, cnt increments; if fs!=0, cnt resets to 0 and the state stays RELEASE.
    - When cnt==DEBOUNCE_CYCLES: B=0, tecla_valida=0, codigo holds its last value, return to SCAN, advance to the next column, clear the divider.
- Multiple rows in one column: B carries the full vector; codigo uses the lowest-index set row.
- A key in another column pressed while PRESSED is invisible, because the column is frozen.
- Latency: B becomes nonzero exactly 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a stable press lands on the active column outside blanking.
- B and tecla_valida always change in the same cycle.
- B never goes directly from one nonzero value to another; B=0 for at least one cycle between keys.
- All outputs are registered; no combinational path from filas to any output.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset, hold rst 3 cycles, filas=0 -> columnas 0001,0010,0100,1000,0001 every 4 cycles; B=0, tecla_valida=0 throughout.
- Assert filas=4'b0100 only while columnas==0010, held 40 cycles ->
  - Column freezes at 0010.
  - B=4'b0100, codigo=4'b1001, tecla_valida=1, exactly 11 cycles after fs sees the press.
  - module_evaluar start pulses once.
- Bounce: toggle filas 0100/0000 every 3 cycles for 30 cycles, then hold -> B stays 0 during toggling, then accepts once after stabilization.
- Release glitch: from PRESSED, filas=0 for 5 cycles, 1 cycle of 0100, then 0 -> B stays 0100 until 8 consecutive zero cycles, then B=0 and rotation resumes at 0100.
- Two rows filas=4'b1010 on column 1000 -> B=1010, codigo=4'b0111.
- Assert rst during DEBOUNCE and again during PRESSED -> next cycle columnas=0001, B=0, codigo=0, tecla_valida=0.
